intr_priority_ctrl: RTL and testbench

Interrupt controller in front of the CPU's single `intr`/`int_ack` pair. It edge-detects up to NUM_SRC I/O interrupt lines, holds them as pending, and applies a software-programmable mask. It arbitrates among enabled pending sources and runs the request/acknowledge/end-of-interrupt handshake with the MCU. Software reaches it through the I/O-space strobes (`io_cs`/`io_wr`/`io_rd`) as a 4-register peripheral.

---
 rtl/intr_priority_ctrl.sv | 163 ++++++++++++++++
 tb/tb_intr_priority_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/intr_priority_ctrl.sv
// Edge-detecting, maskable interrupt controller driving the MCU intr/int_ack/EOI handshake.
// Define INTC_ROTATE_PRIO_EN for rotating priority; the default build uses fixed priority (index 0 highest).
module intr_priority_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               int_ack,
  input  logic               io_cs,
  input  logic               io_wr,
  input  logic               io_rd,
  input  logic [1:0]         io_addr,
  input  logic [31:0]        io_din,
  output logic [31:0]        io_dout,
  output logic               intr
);

  localparam logic [1:0] ADDR_PEND   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_VECTOR = 2'd2;
  localparam logic [1:0] ADDR_EOI    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] active;
  logic [3:0]         vec_id;
  logic [3:0]         win_id;
  logic               wr_pend;
  logic               wr_mask;
  logic               wr_eoi;
  logic               rd_en;
  logic               take_ack;
  logic               unused_din_ok;

  assign wr_pend  = io_cs & io_wr & (io_addr == ADDR_PEND);
  assign wr_mask  = io_cs & io_wr & (io_addr == ADDR_MASK);
  assign wr_eoi   = io_cs & io_wr & (io_addr == ADDR_EOI);
  assign rd_en    = io_cs & io_rd;
  assign rise     = irq_in & ~irq_prev;
  assign active   = pend & mask;
  assign take_ack = (state == REQ) & int_ack;
  assign unused_din_ok = ^io_din;

`ifdef INTC_ROTATE_PRIO_EN
  logic [3:0]  ptr;
  logic [15:0] active16;
  logic [4:0]  idx;
  logic        found;

  assign active16 = 16'(active);

  // Search starts at ptr and wraps; first enabled pending source wins.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(NUM_SRC)) idx = idx - 5'(NUM_SRC);
      if (!found && active16[idx[3:0]]) begin
        found  = 1'b1;
        win_id = idx[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if ((state == SERVICE) && wr_eoi) begin
      ptr <= (vec_id == 4'(NUM_SRC - 1)) ? 4'd0 : vec_id + 4'd1;
    end
  end
`else
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = 4'(i);
    end
  end
`endif

  // Ack and W1C both see the pre-write PEND; a new edge always wins over a clear.
  always_comb begin
    pend_nxt = pend;
    if (wr_pend) pend_nxt = pend_nxt & ~io_din[NUM_SRC-1:0];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (take_ack && (win_id == 4'(i))) pend_nxt[i] = 1'b0;
    end
    pend_nxt = pend_nxt | rise;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_prev <= '0;
      pend     <= '0;
      mask     <= '0;
    end else begin
      irq_prev <= irq_in;
      pend     <= pend_nxt;
      if (wr_mask) mask <= io_din[NUM_SRC-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      intr   <= 1'b0;
      vec_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|active) begin
            state <= REQ;
            intr  <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state  <= SERVICE;
            intr   <= 1'b0;
            vec_id <= win_id;
          end else if (!(|active)) begin
            state <= IDLE;
            intr  <= 1'b0;
          end
        end
        SERVICE: begin
          intr <= 1'b0;
          if (wr_eoi) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    io_dout = '0;
    if (rd_en) begin
      case (io_addr)
        ADDR_PEND:   io_dout = 32'(pend);
        ADDR_MASK:   io_dout = 32'(mask);
        ADDR_VECTOR: io_dout = {(state == SERVICE), 27'd0, vec_id};
        default:     io_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intr_priority_ctrl.sv
// Directed bench for intr_priority_ctrl: expectations queued with each stimulus step, popped when observed.
module tb_intr_priority_ctrl;
  localparam int NUM_SRC = 8;
  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_VEC  = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  logic               clk;
  logic               reset;
  logic [NUM_SRC-1:0] irq_in;
  logic               int_ack;
  logic               io_cs;
  logic               io_wr;
  logic               io_rd;
  logic [1:0]         io_addr;
  logic [31:0]        io_din;
  logic [31:0]        io_dout;
  logic               intr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  intr_priority_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .int_ack (int_ack),
    .io_cs   (io_cs),
    .io_wr   (io_wr),
    .io_rd   (io_rd),
    .io_addr (io_addr),
    .io_din  (io_din),
    .io_dout (io_dout),
    .intr    (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    io_cs   = 1'b1;
    io_rd   = 1'b1;
    io_addr = a;
    #1;
    d       = io_dout;
    io_cs   = 1'b0;
    io_rd   = 1'b0;
  endtask

  task automatic obs_reg(input logic [1:0] a);
    logic [31:0] d;
    rd(a, d);
    observe(d);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    io_cs   = 1'b1;
    io_wr   = 1'b1;
    io_addr = a;
    io_din  = d;
    tick();
    io_cs   = 1'b0;
    io_wr   = 1'b0;
    io_din  = '0;
  endtask

  logic [3:0]  exp_order [4];
  logic [31:0] v;
  int          cyc;

  initial begin
`ifdef INTC_ROTATE_PRIO_EN
    exp_order = '{4'd0, 4'd4, 4'd0, 4'd4};
`else
    exp_order = '{4'd0, 4'd0, 4'd0, 4'd0};
`endif
    reset = 1'b0; irq_in = '0; int_ack = 1'b0;
    io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0; io_addr = '0; io_din = '0;
    tick(); tick();
    reset = 1'b1;

    expect_v("rst_intr", 32'd0);      observe(32'(intr));
    expect_v("rst_dout_idle", 32'd0); observe(io_dout);
    expect_v("rst_pend", 32'd0);      obs_reg(A_PEND);
    expect_v("rst_mask", 32'd0);      obs_reg(A_MASK);
    expect_v("rst_vector", 32'd0);    obs_reg(A_VEC);

    // basic request / ack latency on source 0
    wr_reg(A_MASK, 32'h01);
    irq_in[0] = 1'b1;
    expect_v("lat_edge_cycle", 32'd0); tick(); observe(32'(intr));
    irq_in[0] = 1'b0;
    expect_v("lat_plus1", 32'd1);      tick(); observe(32'(intr));
    int_ack = 1'b1;
    expect_v("ack_intr", 32'd0);       tick(); int_ack = 1'b0; observe(32'(intr));
    expect_v("ack_vector", 32'h8000_0000); obs_reg(A_VEC);
    expect_v("ack_pend", 32'd0);           obs_reg(A_PEND);
    wr_reg(A_EOI, 32'd0);
    expect_v("eoi_vector", 32'd0);         obs_reg(A_VEC);

    // masked source latches but cannot request until unmasked
    wr_reg(A_MASK, 32'h00);
    irq_in[5] = 1'b1; tick(); irq_in[5] = 1'b0; tick();
    expect_v("masked_pend", 32'h20); obs_reg(A_PEND);
    expect_v("masked_intr", 32'd0);  observe(32'(intr));
    wr_reg(A_MASK, 32'h20);
    expect_v("unmask_intr", 32'd1);  tick(); observe(32'(intr));
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    expect_v("vec5", 32'h8000_0005); obs_reg(A_VEC);
    wr_reg(A_EOI, 32'd0);

    // higher-priority arrival during REQ wins the ack
    wr_reg(A_MASK, 32'h0A);
    irq_in[3] = 1'b1; tick(); irq_in[3] = 1'b0; tick();
    expect_v("req3_intr", 32'd1); observe(32'(intr));
    irq_in[1] = 1'b1; tick(); irq_in[1] = 1'b0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    expect_v("prio_vec", 32'h8000_0001);  obs_reg(A_VEC);
    expect_v("prio_pend", 32'h08);        obs_reg(A_PEND);
    wr_reg(A_EOI, 32'd0);
    expect_v("eoi_idle_intr", 32'd0);     observe(32'(intr));
    expect_v("rereq_intr", 32'd1);        tick(); observe(32'(intr));
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    expect_v("vec3", 32'h8000_0003);      obs_reg(A_VEC);
    expect_v("pend_after3", 32'd0);       obs_reg(A_PEND);
    wr_reg(A_EOI, 32'd0);

    // W1C withdraws the request; set beats clear on the same edge
    wr_reg(A_MASK, 32'h04);
    irq_in[2] = 1'b1; tick(); irq_in[2] = 1'b0; tick();
    expect_v("req2_intr", 32'd1); observe(32'(intr));
    wr_reg(A_PEND, 32'hFF);
    expect_v("w1c_pend", 32'd0);      obs_reg(A_PEND);
    expect_v("w1c_drop_intr", 32'd0); tick(); observe(32'(intr));
    expect_v("w1c_idle_intr", 32'd0); tick(); observe(32'(intr));
    irq_in[2] = 1'b1;
    wr_reg(A_PEND, 32'h04);
    irq_in[2] = 1'b0;
    expect_v("set_wins_pend", 32'h04); obs_reg(A_PEND);
    expect_v("req2b_intr", 32'd1);     tick(); observe(32'(intr));
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    expect_v("svc2_vec", 32'h8000_0002); obs_reg(A_VEC);

    // reset during SERVICE
    reset = 1'b0; tick(); reset = 1'b1;
    expect_v("rst_svc_intr", 32'd0); observe(32'(intr));
    expect_v("rst_svc_vec", 32'd0);  obs_reg(A_VEC);
    expect_v("rst_svc_pend", 32'd0); obs_reg(A_PEND);
    expect_v("rst_svc_mask", 32'd0); obs_reg(A_MASK);

    // back-to-back service order with sources 0 and 4 kept pending
    wr_reg(A_MASK, 32'h11);
    irq_in = 8'h11; tick(); irq_in = '0;
    for (int n = 0; n < 4; n++) begin
      cyc = 0;
      while (intr !== 1'b1 && cyc < 10) begin
        tick();
        cyc++;
      end
      expect_v($sformatf("order_req_%0d", n), 32'd1); observe(32'(intr));
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      rd(A_VEC, v);
      expect_v($sformatf("order_%0d", n), 32'h8000_0000 | 32'(exp_order[n])); observe(v);
      wr_reg(A_EOI, 32'd0);
      irq_in[v[2:0]] = 1'b1; tick(); irq_in = '0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
